// File: rtl/booth_mult_param_if.sv
// Host-side bundle for the sequential Booth multiplier: operand/start request
// going in, product with fin/ocupado status coming back.
interface booth_mult_param_if #(
  parameter int N = 4
);
  logic           start;
  logic           signo;
  logic [N-1:0]   initQ;
  logic [N-1:0]   initM;
  logic [2*N-1:0] resultado;
  logic           fin;
  logic           ocupado;

  modport master (
    output start, signo, initQ, initM,
    input  resultado, fin, ocupado
  );

  modport slave (
    input  start, signo, initQ, initM,
    output resultado, fin, ocupado
  );
endinterface

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock, with its own
// IDLE/CALC/DONE controller and a registered product that holds between ops.
module booth_mult_param #(
  parameter int N = 4
) (
  input logic              clk,
  input logic              rst_n,
  booth_mult_param_if.slave bus
);

  // One guard bit makes unsigned operands exact under a signed Booth recoding.
  localparam int W  = N + 1;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     q_reg;
  logic             q1_reg;
  logic [W-1:0]     m_reg;
  logic [CW-1:0]    count_reg;
  logic [2*N-1:0]   resultado_reg;
  logic             fin_reg;
  logic             ocupado_reg;

  logic [W-1:0]     q_ext;
  logic [W-1:0]     m_ext;
  logic [W-1:0]     sum_next;
  logic [W-1:0]     a_next;
  logic [W-1:0]     q_next;
  logic             q1_next;
  logic [2*N-1:0]   resultado_next;

  // Guard bit is the operand MSB for signed operation, zero for unsigned.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_ext
      if (gi < N) begin : g_low
        assign q_ext[gi] = bus.initQ[gi];
        assign m_ext[gi] = bus.initM[gi];
      end else begin : g_guard
        assign q_ext[gi] = bus.signo & bus.initQ[N-1];
        assign m_ext[gi] = bus.signo & bus.initM[N-1];
      end
    end
  endgenerate

  always_comb begin
    sum_next = a_reg;
    case ({q_reg[0], q1_reg})
      2'b10:   sum_next = a_reg - m_reg;
      2'b01:   sum_next = a_reg + m_reg;
      default: sum_next = a_reg;
    endcase
    a_next         = {sum_next[W-1], sum_next[W-1:1]};
    q_next         = {sum_next[0], q_reg[W-1:1]};
    q1_next        = q_reg[0];
    // Low 2N bits of the 2W-bit {A,Q} pair after the final step.
    resultado_next = {a_next[N-2:0], q_next};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      q_reg         <= '0;
      q1_reg        <= 1'b0;
      m_reg         <= '0;
      count_reg     <= '0;
      resultado_reg <= '0;
      fin_reg       <= 1'b0;
      ocupado_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          fin_reg <= 1'b0;
          if (bus.start) begin
            a_reg       <= '0;
            q_reg       <= q_ext;
            q1_reg      <= 1'b0;
            m_reg       <= m_ext;
            count_reg   <= CW'(W);
            ocupado_reg <= 1'b1;
            state_reg   <= CALC;
          end
        end
        CALC: begin
          a_reg     <= a_next;
          q_reg     <= q_next;
          q1_reg    <= q1_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            resultado_reg <= resultado_next;
            fin_reg       <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          fin_reg     <= 1'b0;
          ocupado_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        default: begin
          fin_reg     <= 1'b0;
          ocupado_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign bus.resultado = resultado_reg;
  assign bus.fin       = fin_reg;
  assign bus.ocupado   = ocupado_reg;

endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param at N=4 and N=8: arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_booth_mult_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mult_param_if #(.N(4)) if4 ();
  booth_mult_param_if #(.N(8)) if8 ();

  booth_mult_param #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  booth_mult_param #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  int n_assert = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Exact integer product of two n-bit operands, truncated to 2n bits.
  function automatic logic [15:0] ref_prod(input int n, input bit s,
                                           input logic [7:0] q, input logic [7:0] m);
    longint a, b, p;
    a = longint'(q);
    b = longint'(m);
    if (s && q[n-1]) a = a - (longint'(1) << n);
    if (s && m[n-1]) b = b - (longint'(1) << n);
    p = a * b;
    return 16'(p & ((longint'(1) << (2 * n)) - 1));
  endfunction

  // Model: accept while idle, result appears W cycles later for one cycle,
  // then one more cycle before the next start can be taken.
  bit          b4, b8;
  int          c4, c8;
  logic [7:0]  p4, r4;
  logic [15:0] p8, r8;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b4 <= 1'b0; c4 <= 0; p4 <= '0; r4 <= '0;
    end else if (!b4) begin
      if (if4.start) begin
        b4 <= 1'b1; c4 <= 5;
        p4 <= 8'(ref_prod(4, if4.signo, {4'b0, if4.initQ}, {4'b0, if4.initM}));
      end
    end else if (c4 == 0) begin
      b4 <= 1'b0;
    end else begin
      c4 <= c4 - 1;
      if (c4 == 1) r4 <= p4;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b8 <= 1'b0; c8 <= 0; p8 <= '0; r8 <= '0;
    end else if (!b8) begin
      if (if8.start) begin
        b8 <= 1'b1; c8 <= 9;
        p8 <= ref_prod(8, if8.signo, if8.initQ, if8.initM);
      end
    end else if (c8 == 0) begin
      b8 <= 1'b0;
    end else begin
      c8 <= c8 - 1;
      if (c8 == 1) r8 <= p8;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc fin4",     64'(if4.fin),       64'(b4 && c4 == 0));
      check("cyc ocupado4", 64'(if4.ocupado),   64'(b4));
      check("cyc res4",     64'(if4.resultado), 64'(r4));
      check("cyc fin8",     64'(if8.fin),       64'(b8 && c8 == 0));
      check("cyc ocupado8", 64'(if8.ocupado),   64'(b8));
      check("cyc res8",     64'(if8.resultado), 64'(r8));
    end
  end

  // One directed operation; latency counted in rising edges after acceptance.
  task automatic run_op(input int width, input string tag, input bit s,
                        input logic [7:0] q, input logic [7:0] m,
                        input logic [15:0] exp_res, input int exp_lat);
    int   cyc;
    logic f;
    @(negedge clk);
    if (width == 4) begin
      if4.signo = s; if4.initQ = q[3:0]; if4.initM = m[3:0]; if4.start = 1'b1;
    end else begin
      if8.signo = s; if8.initQ = q; if8.initM = m; if8.start = 1'b1;
    end
    @(negedge clk);
    if4.start = 1'b0;
    if8.start = 1'b0;
    cyc = 0;
    f   = (width == 4) ? if4.fin : if8.fin;
    while (!f && cyc < 40) begin
      @(negedge clk);
      cyc++;
      f = (width == 4) ? if4.fin : if8.fin;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    if (width == 4) check({tag, " result"}, 64'(if4.resultado), 64'(exp_res[7:0]));
    else            check({tag, " result"}, 64'(if8.resultado), 64'(exp_res));
    $display("op %s: signo=%0b Q=%0h M=%0h -> resultado=%0h after %0d cycles",
             tag, s, q, m, (width == 4) ? 16'(if4.resultado) : if8.resultado, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fins;
    logic [7:0] held;
    if4.start = 1'b0; if4.signo = 1'b0; if4.initQ = '0; if4.initM = '0;
    if8.start = 1'b0; if8.signo = 1'b0; if8.initQ = '0; if8.initM = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("reset res4",     64'(if4.resultado), 64'h0);
    check("reset fin4",     64'(if4.fin),       64'h0);
    check("reset ocupado4", 64'(if4.ocupado),   64'h0);
    check("reset res8",     64'(if8.resultado), 64'h0);
    check("reset fin8",     64'(if8.fin),       64'h0);
    check("reset ocupado8", 64'(if8.ocupado),   64'h0);
    cmp_en = 1'b1;

    run_op(4, "s -7*5",   1'b1, 8'h09, 8'h05, 16'h00DD, 5);
    run_op(4, "u 9*5",    1'b0, 8'h09, 8'h05, 16'h002D, 5);
    run_op(4, "u 15*15",  1'b0, 8'h0F, 8'h0F, 16'h00E1, 5);
    run_op(4, "s -8*-8",  1'b1, 8'h08, 8'h08, 16'h0040, 5);
    run_op(4, "s 0*7",    1'b1, 8'h00, 8'h07, 16'h0000, 5);
    run_op(4, "s 7*-8",   1'b1, 8'h07, 8'h08, 16'h00C8, 5);
    run_op(8, "s -128*127", 1'b1, 8'h80, 8'h7F, 16'hC080, 9);
    run_op(8, "u 255*255",  1'b0, 8'hFF, 8'hFF, 16'hFE01, 9);
    run_op(8, "s -128*-128", 1'b1, 8'h80, 8'h80, 16'h4000, 9);

    // A second start during CALC must be ignored.
    @(negedge clk);
    if4.signo = 1'b1; if4.initQ = 4'h9; if4.initM = 4'h5; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if4.signo = 1'b0; if4.initQ = 4'hF; if4.initM = 4'hF; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    fins = 0;
    held = 8'h00;
    repeat (10) begin
      @(negedge clk);
      if (if4.fin) begin
        fins++;
        held = if4.resultado;
      end
    end
    check("midcalc fin count", 64'(fins), 64'd1);
    check("midcalc result",    64'(held), 64'hDD);
    $display("op midcalc start: fin pulses=%0d resultado=%0h", fins, held);

    // Reset two cycles into CALC aborts the operation.
    @(negedge clk);
    if4.signo = 1'b0; if4.initQ = 4'h9; if4.initM = 4'h5; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort res4",     64'(if4.resultado), 64'h0);
    check("abort fin4",     64'(if4.fin),       64'h0);
    check("abort ocupado4", 64'(if4.ocupado),   64'h0);
    check("abort res8",     64'(if8.resultado), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fins = 0;
    repeat (10) begin
      @(negedge clk);
      if (if4.fin) fins++;
    end
    check("abort no fin", 64'(fins), 64'd0);
    $display("op reset mid-CALC: fin pulses after abort=%0d", fins);
    run_op(4, "post-reset u 9*5", 1'b0, 8'h09, 8'h05, 16'h002D, 5);

    // Back-to-back sweep with start held high and operands changing every cycle.
    @(negedge clk);
    if4.start = 1'b1;
    if8.start = 1'b1;
    fins = 0;
    repeat (400) begin
      if4.signo = 1'($urandom_range(0, 1));
      if4.initQ = 4'($urandom);
      if4.initM = 4'($urandom);
      if8.signo = 1'($urandom_range(0, 1));
      if8.initQ = 8'($urandom);
      if8.initM = 8'($urandom);
      @(negedge clk);
      if (if8.fin) begin
        fins++;
        $display("op sweep8: resultado=%0h model=%0h", if8.resultado, r8);
      end
    end
    if4.start = 1'b0;
    if8.start = 1'b0;
    check("sweep8 throughput", 64'(fins), 64'd36);
    repeat (15) @(negedge clk);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
